// File: rtl/csel_add_sched_if.sv
// Interface for csel_add_sched: requester handshake, response channel and
// the shared 16-bit adder slice. The optional req_sub bit is present only
// when CSEL_ADD_SCHED_SUB_EN is defined.
interface csel_add_sched_if #(
  parameter int NREQ  = 2,
  parameter int WORDS = 2
);
  localparam int W   = 16 * WORDS;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
`ifdef CSEL_ADD_SCHED_SUB_EN
  logic [NREQ-1:0]   req_sub;
`endif

  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_sum;
  logic              rsp_cout;

  logic [15:0]       add_a;
  logic [15:0]       add_b;
  logic              add_cin;
  logic [15:0]       add_sum;
  logic              add_cout;

  // Scheduler side
  modport slave (
`ifdef CSEL_ADD_SCHED_SUB_EN
    input  req_sub,
`endif
    input  req_valid, req_a, req_b, rsp_ready, add_sum, add_cout,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout,
    output add_a, add_b, add_cin
  );

  // Requesters, response consumer and adder datapath side
  modport master (
`ifdef CSEL_ADD_SCHED_SUB_EN
    output req_sub,
`endif
    output req_valid, req_a, req_b, rsp_ready, add_sum, add_cout,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout,
    input  add_a, add_b, add_cin
  );
endinterface

// File: rtl/csel_add_sched.sv
// csel_add_sched: round-robin scheduler sharing one external 16-bit adder
// slice among NREQ requesters. Each granted operation runs WORDS words,
// LSW first, with the carry chained in a register, and returns the full
// sum plus carry-out on a valid/ready response channel.
// Optional feature macro: CSEL_ADD_SCHED_SUB_EN (adds per-requester req_sub,
// turning the operation into A-B via ~B and carry-in 1).
module csel_add_sched #(
  parameter int NREQ  = 2,
  parameter int WORDS = 2
) (
  input logic              clk,
  input logic              rst_n,
  csel_add_sched_if.slave  bus
);
  localparam int W   = 16 * WORDS;
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WIW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [WIW-1:0] LAST_WORD = WIW'(WORDS - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [IDW-1:0]  id_reg, id_next;
  logic [WIW-1:0]  word_reg, word_next;
  logic            carry_reg, carry_next;
  logic            cout_reg, cout_next;
  logic            sub_reg, sub_next;
  logic [W-1:0]    a_reg, a_next;
  logic [W-1:0]    b_reg, b_next;
  logic            word_we;

  logic            grant_any;
  logic [IDW-1:0]  grant_idx;
  logic            grant_sub;
  int              pos;
  logic [IDW-1:0]  pos_idx;

  wire  [15:0]     a_words [WORDS];
  wire  [15:0]     b_words [WORDS];
  wire  [W-1:0]    sum_flat;
  wire  [NREQ-1:0] ready_vec;

  genvar gi;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    pos       = 0;
    pos_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      pos     = (int'(rr_ptr_reg) + off) % NREQ;
      pos_idx = IDW'(pos);
      if (!grant_any && bus.req_valid[pos_idx]) begin
        grant_any = 1'b1;
        grant_idx = pos_idx;
      end
    end
  end

`ifdef CSEL_ADD_SCHED_SUB_EN
  assign grant_sub = bus.req_sub[grant_idx];
`else
  assign grant_sub = 1'b0;
`endif

  // Accept strobe is one-hot on the granted index and only while idle.
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign ready_vec[gi] = (state_reg == IDLE) && grant_any &&
                             (grant_idx == IDW'(gi));
    end
  endgenerate
  assign bus.req_ready = ready_vec;

  // Per-word operand slices and per-word sum registers.
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic [15:0] sum_word_reg;

      assign a_words[gi] = a_reg[gi*16 +: 16];
      assign b_words[gi] = b_reg[gi*16 +: 16];

      // Capture the adder result for this word when it is the active word.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sum_word_reg <= '0;
        end else if (word_we && (word_reg == WIW'(gi))) begin
          sum_word_reg <= bus.add_sum;
        end
      end

      assign sum_flat[gi*16 +: 16] = sum_word_reg;
    end
  endgenerate

  // Drive the shared adder only while an operation is running.
  always_comb begin
    bus.add_a   = '0;
    bus.add_b   = '0;
    bus.add_cin = 1'b0;
    if (state_reg == RUN) begin
      bus.add_a   = a_words[word_reg];
      bus.add_b   = sub_reg ? ~b_words[word_reg] : b_words[word_reg];
      bus.add_cin = (word_reg == '0) ? sub_reg : carry_reg;
    end
  end

  // Next-state and datapath control for IDLE -> RUN -> RESP.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    id_next     = id_reg;
    word_next   = word_reg;
    carry_next  = carry_reg;
    cout_next   = cout_reg;
    sub_next    = sub_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    word_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          a_next     = bus.req_a[grant_idx*W +: W];
          b_next     = bus.req_b[grant_idx*W +: W];
          sub_next   = grant_sub;
          id_next    = grant_idx;
          word_next  = '0;
          carry_next = 1'b0;
          state_next = RUN;
        end
      end
      RUN: begin
        word_we    = 1'b1;
        carry_next = bus.add_cout;
        if (word_reg == LAST_WORD) begin
          cout_next  = bus.add_cout;
          word_next  = '0;
          state_next = RESP;
        end else begin
          word_next  = word_reg + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          // Pointer moves past the served requester only once it is done.
          rr_ptr_next = (id_reg == LAST_ID) ? '0 : id_reg + 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      id_reg     <= '0;
      word_reg   <= '0;
      carry_reg  <= 1'b0;
      cout_reg   <= 1'b0;
      sub_reg    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      id_reg     <= id_next;
      word_reg   <= word_next;
      carry_reg  <= carry_next;
      cout_reg   <= cout_next;
      sub_reg    <= sub_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
    end
  end

  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_id    = id_reg;
  assign bus.rsp_sum   = sum_flat;
  assign bus.rsp_cout  = cout_reg;

endmodule
